// File: rtl/munoc_axi2apb_multi_bridge.sv
// AXI slave to multi-target APB bridge: one burst in flight, split into APB beats, address-decoded targets.
// Optional access-phase timeout enabled by defining MUNOC_APB_TIMEOUT_EN.
module munoc_axi2apb_multi_bridge #(
  parameter int BW_ADDR        = 32,
  parameter int BW_DATA        = 32,
  parameter int BW_TID         = 4,
  parameter int NUM_SLAVE      = 4,
  parameter int BW_SLAVE_WIN   = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [BW_TID-1:0]             i_rxawid,
  input  logic [BW_ADDR-1:0]            i_rxawaddr,
  input  logic [7:0]                    i_rxawlen,
  input  logic [2:0]                    i_rxawsize,
  input  logic [1:0]                    i_rxawburst,
  input  logic                          i_rxawvalid,
  output logic                          o_rxawready,
  input  logic [BW_DATA-1:0]            i_rxwdata,
  input  logic [BW_DATA/8-1:0]          i_rxwstrb,
  input  logic                          i_rxwlast,
  input  logic                          i_rxwvalid,
  output logic                          o_rxwready,
  output logic [BW_TID-1:0]             o_rxbid,
  output logic [1:0]                    o_rxbresp,
  output logic                          o_rxbvalid,
  input  logic                          i_rxbready,
  input  logic [BW_TID-1:0]             i_rxarid,
  input  logic [BW_ADDR-1:0]            i_rxaraddr,
  input  logic [7:0]                    i_rxarlen,
  input  logic [2:0]                    i_rxarsize,
  input  logic [1:0]                    i_rxarburst,
  input  logic                          i_rxarvalid,
  output logic                          o_rxarready,
  output logic [BW_TID-1:0]             o_rxrid,
  output logic [BW_DATA-1:0]            o_rxrdata,
  output logic [1:0]                    o_rxrresp,
  output logic                          o_rxrlast,
  output logic                          o_rxrvalid,
  input  logic                          i_rxrready,
  output logic [BW_ADDR-1:0]            o_spaddr,
  output logic                          o_spwrite,
  output logic [NUM_SLAVE-1:0]          o_spsel,
  output logic                          o_spenable,
  output logic [BW_DATA-1:0]            o_spwdata,
  output logic [BW_DATA/8-1:0]          o_spwstrb,
  input  logic [NUM_SLAVE*BW_DATA-1:0]  i_sprdata,
  input  logic [NUM_SLAVE-1:0]          i_spready,
  input  logic [NUM_SLAVE-1:0]          i_spslverr
);

  typedef enum logic [2:0] {S_IDLE, S_WDATA, S_SETUP, S_ACCESS, S_BRESP, S_RDATA} state_t;

  state_t               r_state, w_next;
  logic                 r_last_wr, r_is_wr, r_err, r_dec;
  logic [BW_TID-1:0]    r_id;
  logic [BW_ADDR-1:0]   r_addr;
  logic [2:0]           r_size;
  logic [1:0]           r_burst, r_rresp;
  logic [7:0]           r_cnt;
  logic [BW_DATA-1:0]   r_wdata, r_rdata;
  logic [BW_DATA/8-1:0] r_wstrb;

  logic                 w_grant_wr, w_acc_wr, w_acc_rd, w_miss, w_tmo, w_unused;
  logic                 w_sel_ready, w_sel_err, w_apb_done, w_miss_done, w_beat_done, w_beat_err;
  logic [BW_ADDR-1:0]   w_idx_full, w_next_addr;
  logic [NUM_SLAVE-1:0] w_sel;
  logic [BW_DATA-1:0]   w_sel_rdata;
  state_t               w_after_beat;

  // Arbitration: on a tie, grant the direction not granted last.
  assign w_grant_wr = i_rxawvalid && (!i_rxarvalid || !r_last_wr);
  assign w_acc_wr   = !rst && (r_state == S_IDLE) && w_grant_wr;
  assign w_acc_rd   = !rst && (r_state == S_IDLE) && i_rxarvalid && !w_grant_wr;

  // Full upper address is compared so addresses beyond the last window miss.
  assign w_idx_full = r_addr >> BW_SLAVE_WIN;
  assign w_miss     = (w_idx_full >= BW_ADDR'(NUM_SLAVE));

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_sel       = '0;
    w_sel_ready = 1'b0;
    w_sel_err   = 1'b0;
    w_sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVE; i++) begin
      if (!w_miss && (w_idx_full == BW_ADDR'(i))) begin
        w_sel[i]    = 1'b1;
        w_sel_ready = i_spready[i];
        w_sel_err   = i_spslverr[i];
        w_sel_rdata = i_sprdata[i*BW_DATA +: BW_DATA];
      end
    end
  end

`ifdef MUNOC_APB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo;

  always_ff @(posedge clk) begin
    if (rst || (r_state != S_ACCESS)) r_tmo <= '0;
    else                              r_tmo <= r_tmo + TMO_W'(1);
  end

  assign w_tmo    = (r_state == S_ACCESS) && !w_sel_ready && (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
  assign w_unused = i_rxwlast;
`else
  assign w_tmo    = 1'b0;
  assign w_unused = i_rxwlast ^ TIMEOUT_CYCLES[0];
`endif

  assign w_apb_done   = (r_state == S_ACCESS) && (w_sel_ready || w_tmo);
  assign w_miss_done  = (r_state == S_SETUP) && w_miss;
  assign w_beat_done  = w_apb_done || w_miss_done;
  assign w_beat_err   = (w_sel_ready && w_sel_err) || w_tmo;
  assign w_next_addr  = (r_burst == 2'b00) ? r_addr : r_addr + (BW_ADDR'(1) << r_size);
  assign w_after_beat = !r_is_wr ? S_RDATA : ((r_cnt == 8'd0) ? S_BRESP : S_WDATA);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_acc_wr) w_next = S_WDATA;
                else if (w_acc_rd) w_next = S_SETUP;
      S_WDATA:  if (i_rxwvalid) w_next = S_SETUP;
      S_SETUP:  w_next = w_miss ? w_after_beat : S_ACCESS;
      S_ACCESS: if (w_apb_done) w_next = w_after_beat;
      S_BRESP:  if (i_rxbready) w_next = S_IDLE;
      S_RDATA:  if (i_rxrready) w_next = (r_cnt == 8'd0) ? S_IDLE : S_SETUP;
      default:  w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_last_wr <= 1'b0;
      r_is_wr   <= 1'b0;
      r_err     <= 1'b0;
      r_dec     <= 1'b0;
      r_id      <= '0;
      r_addr    <= '0;
      r_size    <= '0;
      r_burst   <= '0;
      r_cnt     <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_rdata   <= '0;
      r_rresp   <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc_wr || w_acc_rd) begin
        r_last_wr <= w_acc_wr;
        r_is_wr   <= w_acc_wr;
        r_id      <= w_acc_wr ? i_rxawid    : i_rxarid;
        r_addr    <= w_acc_wr ? i_rxawaddr  : i_rxaraddr;
        r_cnt     <= w_acc_wr ? i_rxawlen   : i_rxarlen;
        r_size    <= w_acc_wr ? i_rxawsize  : i_rxarsize;
        r_burst   <= w_acc_wr ? i_rxawburst : i_rxarburst;
        r_err     <= 1'b0;
        r_dec     <= 1'b0;
      end
      if ((r_state == S_WDATA) && i_rxwvalid) begin
        r_wdata <= i_rxwdata;
        r_wstrb <= i_rxwstrb;
      end
      if (w_beat_done) begin
        r_rdata <= w_miss_done ? '0 : w_sel_rdata;
        r_rresp <= w_miss_done ? 2'b11 : (w_beat_err ? 2'b10 : 2'b00);
        if (w_miss_done) r_dec <= 1'b1;
        if (w_apb_done && w_beat_err) r_err <= 1'b1;
        if (r_is_wr && (r_cnt != 8'd0)) begin
          r_cnt  <= r_cnt - 8'd1;
          r_addr <= w_next_addr;
        end
      end
      if ((r_state == S_RDATA) && i_rxrready && (r_cnt != 8'd0)) begin
        r_cnt  <= r_cnt - 8'd1;
        r_addr <= w_next_addr;
      end
    end
  end

  assign o_rxawready = w_acc_wr;
  assign o_rxarready = w_acc_rd;
  assign o_rxwready  = (r_state == S_WDATA);
  assign o_rxbvalid  = (r_state == S_BRESP);
  assign o_rxbid     = r_id;
  assign o_rxbresp   = r_dec ? 2'b11 : (r_err ? 2'b10 : 2'b00);
  assign o_rxrvalid  = (r_state == S_RDATA);
  assign o_rxrid     = r_id;
  assign o_rxrdata   = r_rdata;
  assign o_rxrresp   = r_rresp;
  assign o_rxrlast   = (r_state == S_RDATA) && (r_cnt == 8'd0);
  assign o_spaddr    = r_addr;
  assign o_spwrite   = r_is_wr;
  assign o_spsel     = ((r_state == S_SETUP) || (r_state == S_ACCESS)) ? w_sel : '0;
  assign o_spenable  = (r_state == S_ACCESS);
  assign o_spwdata   = r_wdata;
  assign o_spwstrb   = r_wstrb;

endmodule

// File: tb/tb_munoc_axi2apb_multi_bridge.sv
// Directed bench for munoc_axi2apb_multi_bridge: scoreboarded APB accesses and B/R beats against a small slave model.
module tb_munoc_axi2apb_multi_bridge;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]   awid, arid, bid, rid;
  logic [31:0]  awaddr, araddr, wdata, rdata, spaddr, spwdata;
  logic [7:0]   awlen, arlen;
  logic [2:0]   awsize, arsize;
  logic [1:0]   awburst, arburst, bresp, rresp;
  logic [3:0]   wstrb, spsel, spwstrb, spready, spslverr;
  logic         awvalid, awready, arvalid, arready, wlast, wvalid, wready;
  logic         bvalid, bready, rlast, rvalid, rready, spwrite, spenable;
  logic [127:0] sprdata;

  logic         ready_en, err_en;
  logic [31:0]  err_addr;

  munoc_axi2apb_multi_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .i_rxawid(awid), .i_rxawaddr(awaddr), .i_rxawlen(awlen), .i_rxawsize(awsize),
    .i_rxawburst(awburst), .i_rxawvalid(awvalid), .o_rxawready(awready),
    .i_rxwdata(wdata), .i_rxwstrb(wstrb), .i_rxwlast(wlast), .i_rxwvalid(wvalid), .o_rxwready(wready),
    .o_rxbid(bid), .o_rxbresp(bresp), .o_rxbvalid(bvalid), .i_rxbready(bready),
    .i_rxarid(arid), .i_rxaraddr(araddr), .i_rxarlen(arlen), .i_rxarsize(arsize),
    .i_rxarburst(arburst), .i_rxarvalid(arvalid), .o_rxarready(arready),
    .o_rxrid(rid), .o_rxrdata(rdata), .o_rxrresp(rresp), .o_rxrlast(rlast),
    .o_rxrvalid(rvalid), .i_rxrready(rready),
    .o_spaddr(spaddr), .o_spwrite(spwrite), .o_spsel(spsel), .o_spenable(spenable),
    .o_spwdata(spwdata), .o_spwstrb(spwstrb),
    .i_sprdata(sprdata), .i_spready(spready), .i_spslverr(spslverr)
  );

  function automatic logic [31:0] slave_data(input int t, input logic [31:0] a);
    return {4'(t), a[29:2]};
  endfunction

  always_comb begin
    sprdata  = '0;
    spready  = '0;
    spslverr = '0;
    for (int t = 0; t < 4; t++) begin
      sprdata[t*32 +: 32] = slave_data(t, spaddr);
      spready[t]          = ready_en;
      spslverr[t]         = err_en && (spaddr == err_addr);
    end
  end

  typedef struct { logic [31:0] addr; logic wr; logic [3:0] sel; logic [31:0] wdata; logic [3:0] strb; } apb_t;
  typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; logic chk_data; } r_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } b_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; } w_t;

  apb_t apb_q[$];
  r_t   r_q[$];
  b_t   b_q[$];
  w_t   w_q[$];
  byte  grant_log[$];

  int n_pass = 0, n_fail = 0, n_total = 0;
  int cyc = 0, cyc_ar = 0, r_first_cyc = -1, acc_cycles = 0;
  logic psel_seen;
  logic [3:0] sel_at_rvalid;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic w_load();
    w_t x;
    if (w_q.size() != 0) begin
      x = w_q.pop_front();
      wdata = x.data; wstrb = x.strb; wvalid = 1'b1;
    end else wvalid = 1'b0;
  endtask

  // Observe just before the coming posedge; inputs change only right after the negedge.
  task automatic tick();
    apb_t ea; r_t er; b_t eb;
    logic aw_hs, ar_hs, w_hs;
    #1;
    if (spsel != 4'b0) psel_seen = 1'b1;
    if (spenable) acc_cycles++;
    if (rvalid && (r_first_cyc < 0)) r_first_cyc = cyc;
    if (rvalid) sel_at_rvalid = spsel;
    if (spenable && ((spsel & spready) != 4'b0)) begin
      if (apb_q.size() == 0) check("apb_extra", 1, 0);
      else begin
        ea = apb_q.pop_front();
        check("apb_addr", spaddr, ea.addr);
        check("apb_write", spwrite, ea.wr);
        check("apb_sel", spsel, ea.sel);
        if (ea.wr) begin
          check("apb_wdata", spwdata, ea.wdata);
          check("apb_wstrb", spwstrb, ea.strb);
        end
      end
    end
    if (rvalid && rready) begin
      if (r_q.size() == 0) check("r_extra", 1, 0);
      else begin
        er = r_q.pop_front();
        check("r_id", rid, er.id);
        if (er.chk_data) check("r_data", rdata, er.data);
        check("r_resp", rresp, er.resp);
        check("r_last", rlast, er.last);
      end
    end
    if (bvalid && bready) begin
      if (b_q.size() == 0) check("b_extra", 1, 0);
      else begin
        eb = b_q.pop_front();
        check("b_id", bid, eb.id);
        check("b_resp", bresp, eb.resp);
      end
    end
    aw_hs = awvalid && awready;
    ar_hs = arvalid && arready;
    w_hs  = wvalid && wready;
    if (aw_hs) grant_log.push_back("W");
    if (ar_hs) begin grant_log.push_back("R"); cyc_ar = cyc; end
    @(negedge clk);
    cyc++;
    if (aw_hs) awvalid = 1'b0;
    if (ar_hs) arvalid = 1'b0;
    if (w_hs) w_load();
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [1:0] burst);
    awid = id; awaddr = a; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [1:0] burst);
    arid = id; araddr = a; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
  endtask

  task automatic push_w(input logic [31:0] d, input logic [3:0] s);
    w_q.push_back('{data: d, strb: s});
    if (!wvalid) w_load();
  endtask

  task automatic exp_apb(input logic [31:0] a, input logic wr, input logic [3:0] sel,
                         input logic [31:0] d, input logic [3:0] s);
    apb_q.push_back('{addr: a, wr: wr, sel: sel, wdata: d, strb: s});
  endtask

  task automatic exp_r(input logic [3:0] id, input logic [31:0] d, input logic [1:0] resp,
                       input logic last, input logic chk);
    r_q.push_back('{id: id, data: d, resp: resp, last: last, chk_data: chk});
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((r_q.size() != 0 || b_q.size() != 0 || apb_q.size() != 0 || awvalid || arvalid) && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_drain"}, 64'(r_q.size() + b_q.size() + apb_q.size()), 0);
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;
    ready_en = 1'b1; err_en = 1'b0; err_addr = '0;
    psel_seen = 1'b0; sel_at_rvalid = '0;
    @(negedge clk);
    repeat (3) tick();
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_spsel", spsel, 0);
    check("rst_spenable", spenable, 0);
    check("rst_spaddr", spaddr, 0);
    check("rst_rdata", rdata, 0);
    rst = 1'b0;
    tick();

    // Simultaneous AW/AR after reset: write, then read, then the next write.
    grant_log.delete();
    exp_apb(32'h1000, 1'b1, 4'b0010, 32'h1111_2222, 4'hF);
    exp_apb(32'h2000, 1'b0, 4'b0100, 32'h0, 4'h0);
    exp_apb(32'h0010, 1'b1, 4'b0001, 32'h3333_4444, 4'h3);
    b_q.push_back('{id: 4'd2, resp: 2'b00});
    b_q.push_back('{id: 4'd3, resp: 2'b00});
    exp_r(4'd6, slave_data(2, 32'h2000), 2'b00, 1'b1, 1'b1);
    push_w(32'h1111_2222, 4'hF);
    push_w(32'h3333_4444, 4'h3);
    send_aw(4'd2, 32'h1000, 8'd0, 2'b01);
    send_ar(4'd6, 32'h2000, 8'd0, 2'b01);
    for (int n = 0; n < 50 && awvalid; n++) tick();
    send_aw(4'd3, 32'h0010, 8'd0, 2'b01);
    drain("arb");
    check("arb_count", grant_log.size(), 3);
    if (grant_log.size() == 3) begin
      check("arb_first", grant_log[0], "W");
      check("arb_second", grant_log[1], "R");
      check("arb_third", grant_log[2], "W");
    end

    // Single write into target 1.
    exp_apb(32'h1004, 1'b1, 4'b0010, 32'hA5A5_0001, 4'hF);
    b_q.push_back('{id: 4'd3, resp: 2'b00});
    push_w(32'hA5A5_0001, 4'hF);
    send_aw(4'd3, 32'h1004, 8'd0, 2'b01);
    drain("wr1");

    // INCR read of four beats from target 0.
    for (int k = 0; k < 4; k++) begin
      exp_apb(32'(4 * k), 1'b0, 4'b0001, 32'h0, 4'h0);
      exp_r(4'd5, slave_data(0, 32'(4 * k)), 2'b00, k == 3, 1'b1);
    end
    send_ar(4'd5, 32'h0000, 8'd3, 2'b01);
    drain("incr");

    // Single-beat read latency: rvalid three cycles after the AR handshake.
    r_first_cyc = -1;
    exp_apb(32'h2008, 1'b0, 4'b0100, 32'h0, 4'h0);
    exp_r(4'd1, slave_data(2, 32'h2008), 2'b00, 1'b1, 1'b1);
    send_ar(4'd1, 32'h2008, 8'd0, 2'b01);
    drain("lat");
    check("lat_cycles", 64'(r_first_cyc - cyc_ar), 3);

    // FIXED burst keeps the address.
    for (int k = 0; k < 2; k++) begin
      exp_apb(32'h1010, 1'b0, 4'b0010, 32'h0, 4'h0);
      exp_r(4'd4, slave_data(1, 32'h1010), 2'b00, k == 1, 1'b1);
    end
    send_ar(4'd4, 32'h1010, 8'd1, 2'b00);
    drain("fixed");

    // Decode miss: write of two beats and a read beat beyond the last window.
    psel_seen = 1'b0;
    b_q.push_back('{id: 4'd7, resp: 2'b11});
    push_w(32'hDEAD_0000, 4'hF);
    push_w(32'hDEAD_0001, 4'hF);
    send_aw(4'd7, 32'h4000, 8'd1, 2'b01);
    drain("miss_wr");
    exp_r(4'd7, 32'h0, 2'b11, 1'b1, 1'b0);
    send_ar(4'd7, 32'h5000, 8'd0, 2'b01);
    drain("miss_rd");
    check("miss_no_psel", psel_seen, 0);

    // Slave error on the second beat of a read and of a write.
    err_en = 1'b1; err_addr = 32'h3004;
    for (int k = 0; k < 3; k++) begin
      exp_apb(32'h3000 + 32'(4 * k), 1'b0, 4'b1000, 32'h0, 4'h0);
      exp_r(4'd8, slave_data(3, 32'h3000 + 32'(4 * k)), (k == 1) ? 2'b10 : 2'b00, k == 2, 1'b1);
    end
    send_ar(4'd8, 32'h3000, 8'd2, 2'b01);
    drain("err_rd");
    for (int k = 0; k < 3; k++) begin
      exp_apb(32'h3000 + 32'(4 * k), 1'b1, 4'b1000, 32'hC0DE_0000 + 32'(k), 4'hF);
      push_w(32'hC0DE_0000 + 32'(k), 4'hF);
    end
    b_q.push_back('{id: 4'd9, resp: 2'b10});
    send_aw(4'd9, 32'h3000, 8'd2, 2'b01);
    drain("err_wr");
    err_en = 1'b0;

    // Target never ready.
    ready_en = 1'b0;
    acc_cycles = 0;
`ifdef MUNOC_APB_TIMEOUT_EN
    sel_at_rvalid = 4'hF;
    exp_r(4'hA, 32'h0, 2'b10, 1'b1, 1'b0);
    send_ar(4'hA, 32'h0000, 8'd0, 2'b01);
    drain("tmo");
    check("tmo_access_cycles", acc_cycles, 8);
    check("tmo_psel_dropped", sel_at_rvalid, 0);
`else
    send_ar(4'hA, 32'h0000, 8'd0, 2'b01);
    for (int n = 0; n < 1000; n++) tick();
    check("hang_penable", spenable, 1);
    check("hang_psel", spsel, 4'b0001);
    check("hang_rvalid", rvalid, 0);
    rst = 1'b1;
    tick();
    check("midrst_penable", spenable, 0);
    check("midrst_psel", spsel, 0);
    check("midrst_spaddr", spaddr, 0);
    rst = 1'b0;
    tick();
`endif
    ready_en = 1'b1;

    // Recovery read after the stall.
    exp_apb(32'h200C, 1'b0, 4'b0100, 32'h0, 4'h0);
    exp_r(4'hB, slave_data(2, 32'h200C), 2'b00, 1'b1, 1'b1);
    send_ar(4'hB, 32'h200C, 8'd0, 2'b01);
    drain("recover");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
